// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - single-outstanding fetch with JAL/JALR predecode, RAS hints and 2-entry decode queue
module fetch_predecode #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            fetch_req,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            ras_push,
    output logic [XLEN-1:0] ras_push_addr,
    output logic            ras_pop,
    input  logic [XLEN-1:0] ras_top_addr,
    input  logic            ras_empty,
    output logic            dq_valid,
    input  logic            dq_ready,
    output logic [31:0]     dq_inst,
    output logic [XLEN-1:0] dq_pc,
    output logic [XLEN-1:0] dq_pred_pc,
    output logic            dq_pred_taken
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [1:0]      r_count;
    logic            r_head, r_tail;
    logic [31:0]     r_q_inst  [2];
    logic [XLEN-1:0] r_q_pc    [2];
    logic [XLEN-1:0] r_q_pred  [2];
    logic            r_q_taken [2];

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1;
    logic            w_rd_link, w_rs1_link, w_is_jal, w_is_jalr;
    logic [XLEN-1:0] w_jimm, w_pc_plus4, w_pred_pc;
    logic            w_pred_taken, w_push, w_pop;
    logic            w_accept, w_deq, w_qfull, w_fetch_req;

    // Predecode of the returned word against the PC it was fetched from
    assign w_opcode   = imem_rdata[6:0];
    assign w_rd       = imem_rdata[11:7];
    assign w_rs1      = imem_rdata[19:15];
    assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_is_jal   = (w_opcode == 7'b1101111);
    assign w_is_jalr  = (w_opcode == 7'b1100111);
    assign w_jimm     = {{(XLEN-21){imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                         imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + XLEN'(4);

    always_comb begin
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_pred_pc    = w_pc_plus4;
        w_pred_taken = 1'b0;
        if (w_is_jal) begin
            w_push       = w_rd_link;
            w_pred_pc    = r_pc + w_jimm;
            w_pred_taken = 1'b1;
        end else if (w_is_jalr) begin
            w_push = w_rd_link;
            // Link-to-same-link is a coroutine-free call: push only
            w_pop  = w_rs1_link && !(w_rd_link && (w_rs1 == w_rd));
            if (w_pop && !ras_empty) begin
                w_pred_pc    = ras_top_addr;
                w_pred_taken = 1'b1;
            end
        end
    end

    assign w_qfull     = (r_count == 2'(QDEPTH));
    assign w_accept    = (r_state == S_WAIT) && imem_rvalid && !flush;
    assign w_deq       = dq_valid && dq_ready;
    assign w_fetch_req = (r_state == S_REQ) && !flush && !w_qfull && !rst;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:  if (w_fetch_req) w_state_nxt = S_WAIT;
            S_WAIT: if (flush) w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                    else if (imem_rvalid) w_state_nxt = S_REQ;
            S_DROP: if (flush || imem_rvalid) w_state_nxt = S_REQ;
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (flush)
                r_pc <= flush_pc;
            else if (w_accept)
                r_pc <= w_pred_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_q_inst[i]  <= '0;
                r_q_pc[i]    <= '0;
                r_q_pred[i]  <= '0;
                r_q_taken[i] <= 1'b0;
            end
        end else if (flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q_inst[r_tail]  <= imem_rdata;
                r_q_pc[r_tail]    <= r_pc;
                r_q_pred[r_tail]  <= w_pred_pc;
                r_q_taken[r_tail] <= w_pred_taken;
                r_tail            <= ~r_tail;
            end
            if (w_deq)
                r_head <= ~r_head;
            if (w_accept && !w_deq)
                r_count <= r_count + 2'd1;
            else if (!w_accept && w_deq)
                r_count <= r_count - 2'd1;
        end
    end

    assign fetch_req     = w_fetch_req;
    assign fetch_pc      = r_pc;
    assign ras_push      = w_accept && w_push;
    assign ras_pop       = w_accept && w_pop;
    assign ras_push_addr = w_pc_plus4;
    assign dq_valid      = (r_count != 2'd0);
    assign dq_inst       = r_q_inst[r_head];
    assign dq_pc         = r_q_pc[r_head];
    assign dq_pred_pc    = r_q_pred[r_head];
    assign dq_pred_taken = r_q_taken[r_head];
endmodule

// File: doc/fetch_predecode.md
Name: fetch_predecode

Overview:
Fetch-side next-PC unit that sits directly upstream of the return address stack. It issues one instruction fetch at a time and predecodes each returned word for JAL/JALR. It drives RAS push/pop using the RISC-V link-register hint convention and uses the RAS top to predict return targets. Predecoded instructions go into a 2-entry queue with a valid/ready handshake toward decode.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h1eceb000, fetch PC loaded on reset
QDEPTH, 2, decode-queue entries (fixed at 2; other values not supported)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  backend redirect (mispredict/exception)
flush_pc  in  XLEN  redirect target
fetch_req  out  1  fetch request for fetch_pc, one-cycle pulse
fetch_pc  out  XLEN  current fetch address
imem_rvalid  in  1  instruction response valid
imem_rdata  in  32  instruction word for the outstanding request
ras_push  out  1  push request to RAS
ras_push_addr  out  XLEN  return address (pc+4)
ras_pop  out  1  pop request to RAS
ras_top_addr  in  XLEN  RAS top entry
ras_empty  in  1  RAS empty flag
dq_valid  out  1  queue head valid
dq_ready  in  1  decode accepts head
dq_inst  out  32  head instruction
dq_pc  out  XLEN  head PC
dq_pred_pc  out  XLEN  predicted next PC for head
dq_pred_taken  out  1  head predicted to redirect

Behaviour:
- Reset (async): fetch_pc=RESET_PC; state=REQ; queue count=0, head/tail=0; dq_valid=0; ras_push=ras_pop=0; fetch_req=0 while rst is high.
- FSM states:
  - REQ: fetch_req = !flush && count<2. If fetch_req, go to WAIT.
  - WAIT: hold fetch_pc. On imem_rvalid, accept the response, enqueue it, load fetch_pc with the predicted PC, go to REQ.
  - DROP: on imem_rvalid, discard the response with no enqueue and no RAS activity, go to REQ.
- At most one fetch is outstanding. A request is issued only when count<2, so an accepted response always has a free slot.
- Flush has highest priority in every state. Effects: fetch_pc<=flush_pc; queue cleared (count=0, dq_valid=0 next cycle); no ras_push/ras_pop that cycle; WAIT->DROP, REQ/DROP->REQ. If imem_rvalid coincides with flush in WAIT, drop that response and go to REQ.
- Predecode is combinational on imem_rdata and fetch_pc. Link register = x1 or x5. J-imm is sign-extended to XLEN.
  - JAL (opcode 1101111): pred = pc+J-imm, taken=1. Push pc+4 if rd is a link register.
  - JALR (opcode 1100111):
    - rd link, rs1 not link: push only.
    - rs1 link, rd not link: pop only.
    - Both link and rs1==rd: push only.
    - Both link and rs1!=rd: pop and push in the same cycle.
    - Whenever a pop is requested: pred=ras_top_addr, taken=1 if !ras_empty; otherwise pred=pc+4, taken=0 and ras_pop is still asserted (the RAS saturates).
    - JALR with no pop: pred=pc+4, taken=0.
  - All other opcodes, including conditional branches: pred=pc+4, taken=0.
- ras_push/ras_pop pulse for exactly the accept cycle (WAIT && imem_rvalid && !flush). ras_push_addr=pc+4 (mod 2^XLEN).
- Latency: response accepted in cycle N gives dq_valid in N+1. fetch_req can be asserted for the next PC in N+1.
- Queue:
  - Circular buffer with 1-bit pointers.
  - Dequeue when dq_valid && dq_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged; this is legal when full.
  - Outputs are driven from the head entry and stay stable while dq_valid && !dq_ready.
- PC arithmetic wraps modulo 2^XLEN; no alignment checks.

Test Plan:
- Reset -> fetch_pc=32'h1eceb000, fetch_req=1 in the first cycle after rst deasserts, dq_valid=0, ras_push=ras_pop=0.
- Response 32'h008000ef (jal x1,+8) at pc 0x1eceb000 -> ras_push=1 with ras_push_addr=0x1eceb004 for one cycle. Next cycle: fetch_pc=0x1eceb008, dq_pred_taken=1, dq_pred_pc=0x1eceb008.
- Response 32'h00008067 (ret) with ras_empty=0, ras_top_addr=0x1eceb004 -> ras_pop=1, ras_push=0, next fetch_pc=0x1eceb004. Repeat with ras_empty=1 -> pred=pc+4, dq_pred_taken=0.
- Response jalr x1,0(x5) (32'h000280e7) -> ras_push=1 and ras_pop=1 in the same cycle, ras_push_addr=pc+4.
- Hold dq_ready=0 across two non-control responses -> count=2, fetch_req stays 0, head outputs stable. Then dq_ready=1 for one cycle -> one dequeue, fetch_req=1 the following cycle.
- flush with flush_pc=0x1eceb100 while in WAIT -> queue empties. The next imem_rvalid is discarded with no RAS pulse and no enqueue, then fetch_req=1 with fetch_pc=0x1eceb100. Also assert rst mid-WAIT -> immediate return to reset values.
